immediate_encode: RTL and testbench
===================================

// Module: immediate_encode
// PURPOSE
//   Inverse of the immediate generator: packs a 32-bit immediate into RV32 instruction bits [31:7]
//   per IMM_SEL format, merging non-immediate bits (rd/rs/funct) from BASE. Checks range/alignment.
//   2-stage valid/ready pipeline; sits in the instruction-assembly/patch path feeding instruction memory.
//   Round-trip invariant: if ERR==0, then immediate_generate(OUT_FIELDS, IMM_SEL) == IMM.
// PARAMETERS
//   CNT_W  8  width of saturating error counter ERR_COUNT
// PORTS
//   CLK         in   1      clock; all state updates on posedge
//   RESET       in   1      synchronous, active-high reset
//   IN_VALID    in   1      input request valid
//   IN_READY    out  1      block can accept input this cycle
//   IMM         in   32     immediate value (full 32-bit, byte offset for J/B)
//   IMM_SEL     in   3      000 U, 001 J, 010 S, 011 B, 100 I_SIGNED, 101 I_SHIFT, 110 I_UNSIGNED, 111 illegal
//   BASE        in   25     instruction[31:7] template; supplies all non-immediate bits
//   OUT_VALID   out  1      packed result valid
//   OUT_READY   in   1      downstream accepts result
//   OUT_FIELDS  out  25     packed instruction[31:7]
//   ERR         out  3      {SEL_ERR, ALIGN_ERR, RANGE_ERR} for the OUT_FIELDS beat
//   ERR_CLR     in   1      clear ERR_COUNT
//   ERR_COUNT   out  CNT_W  count of accepted beats with ERR!=0, saturating
// BEHAVIOUR
//   Reset: OUT_VALID=0, OUT_FIELDS=0, ERR=0, ERR_COUNT=0, both stage valids 0; in-flight beats dropped.
//   Handshake: transfer iff VALID&READY. S2 loads when ~S2_V | OUT_READY; S1 loads when ~S1_V | S2 loads.
//   IN_READY = ~S1_V | ~S2_V | OUT_READY (combinational from OUT_READY). Throughput 1 beat/cycle.
//   Latency: accepted at edge N -> OUT_VALID at edge N+2 if not stalled. OUT_* stable while OUT_VALID&~OUT_READY.
//   S1: register IMM, IMM_SEL, BASE; compute error flags:
//     U: RANGE if IMM[11:0]!=0.  J: RANGE if IMM[31:20] not all ==IMM[20]; ALIGN if IMM[0].
//     S, I_SIGNED: RANGE if IMM[31:11] not all ==IMM[11].  B: RANGE if IMM[31:12] not all ==IMM[12]; ALIGN if IMM[0].
//     I_SHIFT: RANGE if IMM[31:5]!=0.  I_UNSIGNED: RANGE if IMM[31:12]!=0.  111: SEL_ERR, fields=BASE.
//   S2: pack (F=OUT_FIELDS; unlisted bits from BASE):
//     U: F[24:5]=IMM[31:12].  J: F[24]=IMM[20], F[23:14]=IMM[10:1], F[13]=IMM[11], F[12:5]=IMM[19:12].
//     S: F[24:18]=IMM[11:5], F[4:0]=IMM[4:0].  B: F[24]=IMM[12], F[23:18]=IMM[10:5], F[4:1]=IMM[4:1], F[0]=IMM[11].
//     I_SIGNED/I_UNSIGNED: F[24:13]=IMM[11:0].  I_SHIFT: F[17:13]=IMM[4:0] (F[24:18]=BASE funct7).
//   Errors do not block: beat still emitted, packed from truncated bits, ERR flagged.
//   ERR_COUNT: +1 on OUT_VALID&OUT_READY&(ERR!=0); holds at 2^CNT_W-1. ERR_CLR same cycle as increment -> 0.
//   Simultaneous S1 load and S2 drain: both occur, no bubble. Back-to-back stalls: no beat lost or duplicated.
// TESTING
//   J: IMM=FFF4E8DC, SEL=001, BASE[4:0]=01010, OUT_READY=1 -> 2 cycles later F=1_0001101110_1_01001110_01010, ERR=0.
//   B: IMM=FFFFF20A, SEL=011, BASE=0 -> F=1_010000_0000000000000_0101_0, ERR=0; U: IMM=B0388000 -> F[24:5]=B0388.
//   Errors: I_SIGNED IMM=00000800 -> ERR=001; B IMM=00000003 -> ERR=010; SEL=111 -> ERR=100, F=BASE; ERR_COUNT=3.
//   Backpressure: stream 4 beats, OUT_READY low 3 cycles mid-stream -> IN_READY drops after 2 held, order kept, no loss.
//   Saturation: CNT_W=2, 5 error beats -> ERR_COUNT=3; ERR_CLR with error beat accepted -> 0.
//   Reset mid-stream: RESET with S1,S2 full -> next cycle OUT_VALID=0, IN_READY=1, ERR_COUNT=0.

Source files
------------

// File: rtl/immediate_encode_if.sv
// -----------------------------------------------------------------------------
// immediate_encode_if
//   Bundles the request/response handshake and status signals of the
//   immediate encoder so that producer and consumer can be wired as one port.
//
//   Signals (named from the encoder's point of view):
//     in_valid / in_ready   request handshake
//     imm                   32-bit immediate to pack
//     imm_sel               format select (U/J/S/B/I_SIGNED/I_SHIFT/I_UNSIGNED)
//     base                  instruction[31:7] template (rd/rs/funct bits)
//     out_valid / out_ready response handshake
//     out_fields            packed instruction[31:7]
//     err                   {sel_err, align_err, range_err} of the output beat
//     err_clr               clear the error counter
//     err_count             saturating count of delivered beats with errors
//
//   Modports:
//     master : the side that issues requests and consumes results
//     slave  : the encoder itself
// -----------------------------------------------------------------------------
interface immediate_encode_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      imm;
    logic [2:0]       imm_sel;
    logic [24:0]      base;
    logic             out_valid;
    logic             out_ready;
    logic [24:0]      out_fields;
    logic [2:0]       err;
    logic             err_clr;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, imm, imm_sel, base, out_ready, err_clr,
        input  in_ready, out_valid, out_fields, err, err_count
    );

    modport slave (
        input  in_valid, imm, imm_sel, base, out_ready, err_clr,
        output in_ready, out_valid, out_fields, err, err_count
    );
endinterface

// File: rtl/immediate_encode.sv
// -----------------------------------------------------------------------------
// immediate_encode
//   Inverse of the RV32 immediate generator: scatters a 32-bit immediate into
//   instruction bits [31:7] for the selected format, taking every bit that is
//   not part of the immediate from a BASE template. Range and alignment are
//   checked; a faulty beat is still packed (from the truncated immediate) and
//   delivered with its error flags set. Two-stage valid/ready pipeline.
//
//   Ports:
//     i_clk    clock, all state updates on the rising edge
//     i_reset  synchronous active-high reset; drops any beats in flight
//     bus      immediate_encode_if.slave (request, response, error counter)
//
//   Handshake: a beat moves across an interface on every rising edge where
//   valid and ready are both high. A producer holding valid keeps its payload
//   stable until ready is seen; out_valid/out_fields/err never change while
//   out_valid is high and out_ready is low. in_ready depends combinationally
//   on out_ready so that a full pipeline can accept a new beat in the same
//   cycle the oldest one drains (one beat per cycle, no bubble).
// -----------------------------------------------------------------------------
module immediate_encode #(
    parameter int CNT_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    immediate_encode_if.slave  bus
);

    localparam logic [2:0] SEL_U   = 3'b000;
    localparam logic [2:0] SEL_J   = 3'b001;
    localparam logic [2:0] SEL_S   = 3'b010;
    localparam logic [2:0] SEL_B   = 3'b011;
    localparam logic [2:0] SEL_IS  = 3'b100;
    localparam logic [2:0] SEL_ISH = 3'b101;
    localparam logic [2:0] SEL_IU  = 3'b110;

    // Stage 1: captured request plus its error flags
    logic             r_s1_v;
    logic [31:0]      r_s1_imm;
    logic [2:0]       r_s1_sel;
    logic [24:0]      r_s1_base;
    logic [2:0]       r_s1_err;

    // Stage 2: packed result as presented downstream
    logic             r_s2_v;
    logic [24:0]      r_out_fields;
    logic [2:0]       r_err;
    logic [CNT_W-1:0] r_err_count;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_sel_err;
    logic             w_align_err;
    logic             w_range_err;
    logic [24:0]      w_pack;

    // A stage may load when it is empty or when its content moves on this edge.
    assign w_s2_load  = ~r_s2_v | bus.out_ready;
    assign w_s1_load  = ~r_s1_v | w_s2_load;
    assign w_in_fire  = bus.in_valid & w_s1_load;
    assign w_out_fire = r_s2_v & bus.out_ready;

    assign bus.in_ready   = w_s1_load;
    assign bus.out_valid  = r_s2_v;
    assign bus.out_fields = r_out_fields;
    assign bus.err        = r_err;
    assign bus.err_count  = r_err_count;

    // Error classification of the incoming request. Signed formats require
    // the bits above the immediate's sign bit to be copies of it.
    always_comb begin
        w_sel_err   = 1'b0;
        w_align_err = 1'b0;
        w_range_err = 1'b0;
        case (bus.imm_sel)
            SEL_U:   w_range_err = |bus.imm[11:0];
            SEL_J: begin
                w_range_err = (bus.imm[31:20] != {12{bus.imm[20]}});
                w_align_err = bus.imm[0];
            end
            SEL_S, SEL_IS:
                w_range_err = (bus.imm[31:11] != {21{bus.imm[11]}});
            SEL_B: begin
                w_range_err = (bus.imm[31:12] != {20{bus.imm[12]}});
                w_align_err = bus.imm[0];
            end
            SEL_ISH: w_range_err = |bus.imm[31:5];
            SEL_IU:  w_range_err = |bus.imm[31:12];
            default: w_sel_err   = 1'b1;
        endcase
    end

    // Scatter the stage-1 immediate into instruction[31:7]; F[n] here is
    // instruction bit n+7. Anything not written keeps the template bit.
    always_comb begin
        w_pack = r_s1_base;
        case (r_s1_sel)
            SEL_U:   w_pack[24:5] = r_s1_imm[31:12];
            SEL_J: begin
                w_pack[24]    = r_s1_imm[20];
                w_pack[23:14] = r_s1_imm[10:1];
                w_pack[13]    = r_s1_imm[11];
                w_pack[12:5]  = r_s1_imm[19:12];
            end
            SEL_S: begin
                w_pack[24:18] = r_s1_imm[11:5];
                w_pack[4:0]   = r_s1_imm[4:0];
            end
            SEL_B: begin
                w_pack[24]    = r_s1_imm[12];
                w_pack[23:18] = r_s1_imm[10:5];
                w_pack[4:1]   = r_s1_imm[4:1];
                w_pack[0]     = r_s1_imm[11];
            end
            SEL_IS, SEL_IU: w_pack[24:13] = r_s1_imm[11:0];
            // Shift amount only; funct7 in F[24:18] stays from the template.
            SEL_ISH: w_pack[17:13] = r_s1_imm[4:0];
            default: w_pack = r_s1_base;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_v    <= 1'b0;
            r_s1_imm  <= '0;
            r_s1_sel  <= '0;
            r_s1_base <= '0;
            r_s1_err  <= '0;
        end else if (w_s1_load) begin
            r_s1_v <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_imm  <= bus.imm;
                r_s1_sel  <= bus.imm_sel;
                r_s1_base <= bus.base;
                r_s1_err  <= {w_sel_err, w_align_err, w_range_err};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_v       <= 1'b0;
            r_out_fields <= '0;
            r_err        <= '0;
        end else if (w_s2_load) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_out_fields <= w_pack;
                r_err        <= r_s1_err;
            end
        end
    end

    // Counts delivered faulty beats; clear wins over a simultaneous increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (bus.err_clr) begin
            r_err_count <= '0;
        end else if (w_out_fire && (r_err != 3'b000) && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_immediate_encode.sv
module tb_immediate_encode;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    immediate_encode_if #(.CNT_W(CNT_W)) bus ();

    immediate_encode #(.CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Scoreboard entries are {err, out_fields}
    logic [27:0] exp_q[$];
    int          exp_cnt  = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Call just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input logic [31:0] imm, input logic [2:0] sel, input logic [24:0] base,
                        input logic [2:0] e, input logic [24:0] f);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.imm      = imm;
        bus.imm_sel  = sel;
        bus.base     = base;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back({e, f});
        else    fail_now("in_ready_wait");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compares every delivered beat and tracks the error counter.
    initial begin
        logic [27:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_cnt = 0;
            end else begin
                check("err_count", 32'(bus.err_count), exp_cnt);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL extra_beat: got %h expected none", bus.out_fields);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_fields", 32'(bus.out_fields), 32'(e[24:0]));
                        check("err", 32'(bus.err), 32'(e[27:25]));
                        if (bus.err_clr) exp_cnt = 0;
                        else if (e[27:25] != 3'b000 && exp_cnt < CNT_MAX) exp_cnt++;
                    end
                end else if (bus.err_clr) begin
                    exp_cnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.imm      = '0;
        bus.imm_sel  = '0;
        bus.base     = '0;
        bus.out_ready = 1'b1;
        bus.err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_fields", bus.out_fields, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Legal vectors, back to back
        @(posedge clk); #1;
        send(32'hFFF4E8DC, 3'b001, 25'h000000A, 3'b000, 25'b1_0001101110_1_01001110_01010);
        send(32'hFFFFF20A, 3'b011, 25'h0000000, 3'b000, 25'b1_010000_0000000000000_0101_0);
        send(32'hB0388000, 3'b000, 25'h000001F, 3'b000, {20'hB0388, 5'h1F});
        send(32'hFFFFF8A5, 3'b010, 25'h1FFFFFF, 3'b000, {7'b1000101, 13'h1FFF, 5'b00101});
        send(32'hFFFFF800, 3'b100, 25'h0001234, 3'b000, {12'h800, 13'h1234});
        send(32'h0000001F, 3'b101, {7'b0100000, 5'b10101, 13'h0AB3}, 3'b000,
             {7'b0100000, 5'b11111, 13'h0AB3});
        send(32'h00000FFF, 3'b110, 25'h0000000, 3'b000, {12'hFFF, 13'h0000});
        drain();

        // Error beats: range, alignment, illegal select
        @(posedge clk); #1;
        send(32'h00000800, 3'b100, 25'h0000000, 3'b001, {12'h800, 13'h0000});
        send(32'h00000003, 3'b011, 25'h0000000, 3'b010, 25'h0000002);
        send(32'h12345678, 3'b111, 25'h155AAAA, 3'b100, 25'h155AAAA);
        drain();
        @(negedge clk);
        check("err_count_three", bus.err_count, 3);

        // More errors: counter must hold at its maximum
        @(posedge clk); #1;
        send(32'h12345678, 3'b000, 25'h0000000, 3'b001, {20'h12345, 5'h00});
        send(32'h00100000, 3'b001, 25'h0000000, 3'b001, 25'h1000000);
        send(32'h00000020, 3'b101, 25'h0000000, 3'b001, 25'h0000000);
        send(32'h00001000, 3'b110, 25'h0000000, 3'b001, 25'h0000000);
        drain();
        @(negedge clk);
        check("err_count_sat", bus.err_count, 3);

        // Clear coinciding with delivery of an error beat
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h00000001, 3'b011, 25'h0000000, 3'b010, 25'h0000000);
        for (int i = 0; i < 16 && !bus.out_valid; i++) @(negedge clk);
        check("clr_beat_ready", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.err_clr   = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        drain();
        @(negedge clk);
        check("err_count_clr", bus.err_count, 0);

        // Backpressure: downstream stalls 3 cycles mid-stream
        @(posedge clk); #1;
        fork
            begin
                send(32'h00000001, 3'b110, 25'h0000010, 3'b000, {12'h001, 13'h0010});
                send(32'h00000002, 3'b110, 25'h0000011, 3'b000, {12'h002, 13'h0011});
                send(32'h00000003, 3'b110, 25'h0000012, 3'b000, {12'h003, 13'h0012});
                send(32'h00000004, 3'b110, 25'h0000013, 3'b000, {12'h004, 13'h0013});
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_in_ready_low", bus.in_ready, 0);
                check("bp_out_valid_held", bus.out_valid, 1);
                check("bp_out_fields_held", bus.out_fields, {12'h001, 13'h0010});
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with both stages full
        @(posedge clk); #1;
        send(32'h00000800, 3'b100, 25'h0000000, 3'b001, {12'h800, 13'h0000});
        drain();
        @(negedge clk);
        check("pre_reset_count", bus.err_count, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h00000005, 3'b110, 25'h0000000, 3'b000, {12'h005, 13'h0000});
        send(32'h00000006, 3'b110, 25'h0000000, 3'b000, {12'h006, 13'h0000});
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_err_count", bus.err_count, 0);

        // Pipeline usable again and holds no stale beats
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'hFFF4E8DC, 3'b001, 25'h000000A, 3'b000, 25'b1_0001101110_1_01001110_01010);
        drain();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
